decrypt_sequencer: RTL and testbench

Upstream feeder for the `decrypt` dot-product stage.
- Holds the LWE secret key in a local register file and accepts ciphertext vector entries over a valid/ready stream.
- Drives `decrypt`'s `secretkey_entry` / `ciphertext_entry` / `row` inputs so that each vector is accumulated exactly once, with the accumulator cleared beforehand.
- Captures `decrypt`'s `result` at the correct cycle and presents it as a one-cycle plaintext pulse.

---
 rtl/decrypt_sequencer.sv | 135 +++++++++++++
 tb/tb_decrypt_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer: feeds the decrypt dot-product stage from a local LWE key
// register file and a valid/ready ciphertext stream, then captures the result.
// Ports: key write port (sk_wr_*), ciphertext stream (ct_*), decrypt drive
// (secretkey_entry/ciphertext_entry/row), decrypt result (result_in),
// plaintext pulse (pt_valid/pt_data), busy.
module decrypt_sequencer #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 10,
  parameter int ADDR_WIDTH       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sk_wr_en,
  input  logic [ADDR_WIDTH-1:0]              sk_wr_addr,
  input  logic [CIPHERTEXT_WIDTH-1:0]        sk_wr_data,
  input  logic                               ct_valid,
  output logic                               ct_ready,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] ct_data,
  output logic [CIPHERTEXT_WIDTH-1:0]        secretkey_entry,
  output logic signed [CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
  output logic [DIMENSION:0]                 row,
  input  logic [PLAINTEXT_WIDTH-1:0]         result_in,
  output logic                               pt_valid,
  output logic [PLAINTEXT_WIDTH-1:0]         pt_data,
  output logic                               busy
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int ROW_W = DIMENSION + 1;
  localparam int KEY_N = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STREAM  = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DIM = CNT_W'(DIMENSION);

  // Key file is sized to the full address space so the beat counter can index
  // it directly; entries at or above DIMENSION are never written.
  logic [CIPHERTEXT_WIDTH-1:0] key [KEY_N];

  logic [1:0]       state;
  logic [CNT_W-1:0] count;   // beats accepted so far in the current vector
  logic [CNT_W-1:0] next_k;  // index (1-based) of the beat being accepted
  logic             accept;
  logic             key_we;

  // A key write in the same cycle always blocks the stream, so a write and a
  // beat never land on the same edge.
  assign ct_ready = ((state == S_IDLE) || (state == S_STREAM)) && !sk_wr_en;
  assign accept   = ct_valid && ct_ready;
  assign next_k   = count + CNT_ONE;
  assign busy     = (state != S_IDLE);
  assign key_we   = sk_wr_en && (state == S_IDLE) &&
                    ({1'b0, sk_wr_addr} < CNT_DIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_N; i++) begin
        key[i] <= '0;
      end
    end else if (key_we) begin
      key[sk_wr_addr] <= sk_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      count            <= '0;
      secretkey_entry  <= '0;
      ciphertext_entry <= '0;
      row              <= '0;
      pt_valid         <= 1'b0;
      pt_data          <= '0;
    end else begin
      pt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // row=0 here keeps decrypt's accumulator cleared, including at the
          // edge that accepts the first beat.
          secretkey_entry  <= '0;
          ciphertext_entry <= '0;
          row              <= '0;
          count            <= '0;
          if (accept) begin
            ciphertext_entry <= ct_data;
            secretkey_entry  <= key[count[ADDR_WIDTH-1:0]];
            row              <= ROW_W'(next_k);
            count            <= next_k;
            state            <= (next_k == CNT_DIM) ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            ciphertext_entry <= ct_data;
            secretkey_entry  <= key[count[ADDR_WIDTH-1:0]];
            row              <= ROW_W'(next_k);
            count            <= next_k;
            if (next_k == CNT_DIM) begin
              state <= S_DRAIN;
            end
          end else begin
            // Bubble: zero product leaves the accumulator untouched while
            // row holds its non-zero value.
            secretkey_entry  <= '0;
            ciphertext_entry <= '0;
          end
        end
        S_DRAIN: begin
          // decrypt accumulates the final beat during this cycle.
          secretkey_entry  <= '0;
          ciphertext_entry <= '0;
          state            <= S_CAPTURE;
        end
        S_CAPTURE: begin
          pt_data          <= result_in;
          pt_valid         <= 1'b1;
          secretkey_entry  <= '0;
          ciphertext_entry <= '0;
          row              <= '0;
          count            <= '0;
          state            <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_sequencer.sv
// Bench for decrypt_sequencer with a behavioural decrypt accumulator model.
// Stimulus pushes expected plaintexts; monitors check values, latency and row.
module tb_decrypt_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sk_wr_en;
  logic [3:0]        sk_wr_addr;
  logic [9:0]        sk_wr_data;
  logic              ct_valid;
  logic              ct_ready;
  logic signed [9:0] ct_data;
  logic [9:0]        secretkey_entry;
  logic signed [9:0] ciphertext_entry;
  logic [10:0]       row;
  logic [5:0]        result_in;
  logic              pt_valid;
  logic [5:0]        pt_data;
  logic              busy;

  decrypt_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sk_wr_en         (sk_wr_en),
    .sk_wr_addr       (sk_wr_addr),
    .sk_wr_data       (sk_wr_data),
    .ct_valid         (ct_valid),
    .ct_ready         (ct_ready),
    .ct_data          (ct_data),
    .secretkey_entry  (secretkey_entry),
    .ciphertext_entry (ciphertext_entry),
    .row              (row),
    .result_in        (result_in),
    .pt_valid         (pt_valid),
    .pt_data          (pt_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Behavioural decrypt: row=0 clears, otherwise accumulate sk*ct; the
  // plaintext is the accumulator truncated to 6 bits.
  logic signed [31:0] acc = 32'sd0;
  logic signed [31:0] prod;
  assign prod      = $signed(ciphertext_entry) * $signed({1'b0, secretkey_entry});
  assign result_in = acc[5:0];
  always @(posedge clk) begin
    if (row == 11'd0) acc <= 32'sd0;
    else              acc <= acc + prod;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int beats  = 0;
  int first_acc = 0;
  int last_acc  = 0;
  int exp_q[$];
  int t_q[$];
  int ct_vec[10];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Handshake tracker: row must equal the index of the last accepted beat
  // mid-vector; the final accept schedules the expected pt_valid cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      beats = 0;
    end else begin
      if (beats > 0 && beats < 10) chk("row_mid", int'(row), beats);
      if (ct_valid && ct_ready) begin
        beats++;
        if (beats == 1) first_acc = cyc + 1;
        if (beats == 10) begin
          last_acc = cyc + 1;
          t_q.push_back(cyc + 3);
          beats = 0;
        end
      end
    end
  end

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && pt_valid) begin
      if (exp_q.size() == 0) begin
        chk("pt_unexpected", 1, 0);
      end else begin
        chk("pt_data", int'(pt_data), exp_q.pop_front());
        if (t_q.size() == 0) chk("pt_timing_missing", 1, 0);
        else                 chk("pt_latency", cyc, t_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int v);
    for (int i = 0; i < 10; i++) begin
      sk_wr_en   = 1'b1;
      sk_wr_addr = 4'(i);
      sk_wr_data = 10'(v);
      tick();
    end
    sk_wr_en = 1'b0;
  endtask

  task automatic set_vec(input int base, input int step);
    for (int i = 0; i < 10; i++) ct_vec[i] = base + step * i;
  endtask

  // Sends beats ct_vec[start .. start+n-1]; leaves ct_valid as it was last set.
  task automatic send_beats(input int start, input int n, input bit bubbles);
    for (int b = 0; b < n; b++) begin
      bit got;
      int guard;
      ct_valid = 1'b1;
      ct_data  = 10'(ct_vec[start + b]);
      guard    = 0;
      got      = 1'b0;
      while (!got && guard < 100) begin
        @(negedge clk);
        got = ct_ready;
        tick();
        guard++;
      end
      if (!got) chk("accept_timeout", 0, 1);
      if (bubbles) begin
        ct_valid = 1'b0;
        ct_data  = '0;
        tick();
      end
    end
  endtask

  task automatic idle_wait();
    int guard;
    ct_valid = 1'b0;
    ct_data  = '0;
    guard    = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    if (busy) chk("idle_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sk_entry"}, int'(secretkey_entry), 0);
    chk({tag, "_ct_entry"}, int'(ciphertext_entry), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_pt_valid"}, int'(pt_valid), 0);
    chk({tag, "_pt_data"}, int'(pt_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ct_ready"}, int'(ct_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int saved_last;
    rst_n      = 1'b0;
    sk_wr_en   = 1'b0;
    sk_wr_addr = '0;
    sk_wr_data = '0;
    ct_valid   = 1'b0;
    ct_data    = '0;
    repeat (2) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic sum: key 1, data 1..10 -> 55
    load_key(1);
    set_vec(1, 1);
    exp_q.push_back(55);
    send_beats(0, 10, 1'b0);
    idle_wait();

    // Wrap: key 100, data 1 -> 1000 mod 64 = 40
    load_key(100);
    set_vec(1, 0);
    exp_q.push_back(40);
    send_beats(0, 10, 1'b0);
    idle_wait();

    // Bubbles: key 1, data 1..10 with valid toggling -> 55
    load_key(1);
    set_vec(1, 1);
    exp_q.push_back(55);
    send_beats(0, 10, 1'b1);
    idle_wait();

    // Back-to-back: key 3, data 2, valid held -> 60, 60, next accept at E+3
    load_key(3);
    set_vec(2, 0);
    exp_q.push_back(60);
    exp_q.push_back(60);
    send_beats(0, 10, 1'b0);
    saved_last = last_acc;
    send_beats(0, 10, 1'b0);
    chk("b2b_accept_gap", first_acc - saved_last, 3);
    idle_wait();

    // Key write during STREAM is blocked and ignored
    load_key(1);
    set_vec(1, 1);
    exp_q.push_back(55);
    exp_q.push_back(55);
    send_beats(0, 5, 1'b0);
    sk_wr_en   = 1'b1;
    sk_wr_addr = 4'd0;
    sk_wr_data = 10'd50;
    ct_valid   = 1'b1;
    ct_data    = 10'(ct_vec[5]);
    @(negedge clk);
    chk("stream_wr_ct_ready", int'(ct_ready), 0);
    tick();
    sk_wr_en = 1'b0;
    send_beats(5, 5, 1'b0);
    idle_wait();
    send_beats(0, 10, 1'b0);
    idle_wait();

    // Write + valid in IDLE: write wins, no beat consumed -> 5 + 54 = 59
    sk_wr_en   = 1'b1;
    sk_wr_addr = 4'd0;
    sk_wr_data = 10'd5;
    ct_valid   = 1'b1;
    ct_data    = 10'sd7;
    @(negedge clk);
    chk("idle_wr_ct_ready", int'(ct_ready), 0);
    tick();
    sk_wr_en = 1'b0;
    ct_valid = 1'b0;
    @(negedge clk);
    chk("idle_wr_busy", int'(busy), 0);
    tick();
    exp_q.push_back(59);
    send_beats(0, 10, 1'b0);
    idle_wait();

    // Reset mid-vector: aborts, outputs zero, key lost
    load_key(1);
    send_beats(0, 5, 1'b0);
    ct_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_zero_outputs("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("midrst_no_pulse_pending", exp_q.size(), 0);
    exp_q.push_back(0);
    send_beats(0, 10, 1'b0);
    idle_wait();
    load_key(1);
    exp_q.push_back(55);
    send_beats(0, 10, 1'b0);
    idle_wait();

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("timing_queue_drained", t_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
